alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the ALU's operand and operation-select inputs; it is the producer side of the ALU interface.
- Accepts an instruction, its PC and the two register-file read values over a valid/ready handshake. Decodes OP, OP-IMM, LUI and AUIPC.
- Registers in_data1, in_data2, 4-bit select and rd into a two-entry elastic buffer toward the execute stage. Flags every other instruction as illegal.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- ILLEGAL_PASS, 1, 1 = illegal instructions are issued with out_illegal=1; 0 = illegal instructions are consumed and dropped.

Ports:
- in_clk  input  1  clock, rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_dec_valid  input  1  upstream holds a valid instruction.
- out_dec_ready  output  1  stage can accept an instruction.
- in_instr  input  32  instruction word.
- in_pc  input  32  PC of in_instr.
- in_rs1_val  input  32  register-file value of rs1.
- in_rs2_val  input  32  register-file value of rs2.
- out_alu_valid  output  1  issue outputs are valid.
- in_alu_ready  input  1  execute stage accepts this cycle.
- out_data1  output  32  ALU operand 1.
- out_data2  output  32  ALU operand 2.
- out_select  output  4  ALU select, {funct3, alt}.
- out_rd  output  5  destination register.
- out_illegal  output  1  instruction was not decodable.

Behaviour:
- Reset (asynchronous, takes effect immediately and mid-transfer):
  - out_alu_valid=0, out_dec_ready=1.
  - out_data1, out_data2, out_select, out_rd and out_illegal are all 0.
  - Both buffer entries are emptied; any in-flight instruction is discarded.
- Handshakes:
  - Input transfer occurs when in_dec_valid && out_dec_ready.
  - Output transfer occurs when out_alu_valid && in_alu_ready.
  - Output fields are held stable while out_alu_valid && !in_alu_ready.
- Latency: an accepted instruction appears on the outputs 1 cycle later if the buffer was empty.
- Elastic buffer: one main entry plus one skid entry.
  - out_dec_ready is a pure register: 1 iff the skid entry is empty.
  - If the main entry is full and not draining, an accept goes to the skid entry.
  - On drain, skid moves to main.
  - Simultaneous accept and drain with an empty skid entry: the main entry is replaced in the same cycle, so full throughput of 1 per cycle is sustained.
- Decode. Select encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
  - OP (0110011):
    - data1=rs1_val, data2=rs2_val, select={funct3, funct7[5]}.
    - Legal iff funct7==0000000, or funct7==0100000 with funct3 in {000, 101}.
  - OP-IMM (0010011):
    - data1=rs1_val.
    - funct3=001/101: data2=zero-extended instr[24:20], select={funct3, instr[30]}. Legal iff instr[31:25] is 0000000, or 0100000 with funct3=101.
    - Other funct3: data2=sign-extended instr[31:20], select={funct3, 0}; always legal. ADDI never yields SUB.
  - LUI (0110111): data1=0, data2={instr[31:12], 12'b0}, select=ADD.
  - AUIPC (0010111): data1=pc, data2={instr[31:12], 12'b0}, select=ADD.
  - Any other opcode is illegal.
- Illegal instructions:
  - data1=0, data2=0, select=0000, out_rd=0, out_illegal=1.
  - ILLEGAL_PASS=0: the instruction is accepted but never sets out_alu_valid.
- out_rd = instr[11:7] for every legal instruction, including rd=0; no suppression for rd=0.
- No arithmetic is performed here; all immediate widening is sign- or zero-extension to 32 bits exactly as listed above.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=7, in_alu_ready=1 → next cycle valid, data1=5, data2=7, select=0000, rd=3, illegal=0.
- SUB 0x402081B3 back-to-back with SRAI x5,x6,3 (0x40335293), rs1=0x80000000 → select 0001 then 1011 with data2=3, rd=5; one issue per cycle.
- ADDI x1,x0,-1 (0xFFF00093) → data2=0xFFFFFFFF, select=0000. LUI x1,0x12345 (0x123450B7) → data1=0, data2=0x12345000. AUIPC with pc=0x100 → data1=0x100.
- Backpressure: in_alu_ready=0 while 3 instructions are offered → two accepted, out_dec_ready=0 after the second, outputs held stable. Release → all three issue in order, nothing lost or duplicated.
- Illegal: 0x0220_81B3 (MUL encoding) and opcode 0x7F → ILLEGAL_PASS=1 gives illegal=1 with data1, data2, select and rd all 0; ILLEGAL_PASS=0 gives no valid output and the next legal instruction issues normally.
- Assert in_reset with both entries full → out_alu_valid=0 and out_dec_ready=1 immediately; after release, the buffer is empty.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decode-side handshake in, ALU-side operands out.
interface alu_issue_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_dec_valid;
    logic            out_dec_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic            out_alu_valid;
    logic            in_alu_ready;
    logic [XLEN-1:0] out_data1;
    logic [XLEN-1:0] out_data2;
    logic [3:0]      out_select;
    logic [4:0]      out_rd;
    logic            out_illegal;

    // Upstream/downstream environment view.
    modport master (
        output in_dec_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, in_alu_ready,
        input  out_dec_ready, out_alu_valid, out_data1, out_data2, out_select, out_rd,
               out_illegal
    );

    // Issue-stage view.
    modport slave (
        input  in_dec_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, in_alu_ready,
        output out_dec_ready, out_alu_valid, out_data1, out_data2, out_select, out_rd,
               out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands and select,
// buffered in a main + skid elastic buffer toward execute.
module alu_issue_stage #(
    parameter int unsigned XLEN         = 32,  // only 32 is supported
    parameter bit          ILLEGAL_PASS = 1'b1
) (
    input logic               in_clk,
    input logic               in_reset,
    alu_issue_stage_if.slave  bus
);
    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [3:0]      sel;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t dec;
    logic   legal;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       accept, drain, push;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];

    // Decode the offered instruction into a buffer entry.
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        unique case (opcode)
            OpcOp: begin
                dec.data1 = bus.in_rs1_val;
                dec.data2 = bus.in_rs2_val;
                dec.sel   = {funct3, funct7[5]};
                legal     = (funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OpcOpImm: begin
                dec.data1 = bus.in_rs1_val;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shifts: shamt zero-extended, instr[30] picks SRA.
                    dec.data2 = {27'b0, bus.in_instr[24:20]};
                    dec.sel   = {funct3, bus.in_instr[30]};
                    legal     = (funct7 == 7'b0000000) ||
                                (funct7 == 7'b0100000 && funct3 == 3'b101);
                end else begin
                    // instr[30] is immediate data here, so ADDI never becomes SUB.
                    dec.data2 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
                    dec.sel   = {funct3, 1'b0};
                    legal     = 1'b1;
                end
            end
            OpcLui: begin
                dec.data1 = '0;
                dec.data2 = {bus.in_instr[31:12], 12'b0};
                dec.sel   = 4'b0000;
                legal     = 1'b1;
            end
            OpcAuipc: begin
                dec.data1 = bus.in_pc;
                dec.data2 = {bus.in_instr[31:12], 12'b0};
                dec.sel   = 4'b0000;
                legal     = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            dec.rd  = bus.in_instr[11:7];
            dec.ill = 1'b0;
        end else begin
            dec     = '0;
            dec.ill = 1'b1;
        end
    end

    assign accept = bus.in_dec_valid && bus.out_dec_ready;
    assign drain  = main_valid_q && bus.in_alu_ready;
    // Dropped illegal instructions are accepted but never stored.
    assign push   = accept && (legal || ILLEGAL_PASS);

    // Elastic buffer next state: skid refills main on drain, accept lands in the free slot.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            if (skid_valid_q) begin
                // Ready was low, so no accept can coincide with this.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                main_d = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            if (main_valid_q) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end
    end

    // Buffer state registers with asynchronous clear.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.out_dec_ready = ~skid_valid_q;
    assign bus.out_alu_valid = main_valid_q;
    assign bus.out_data1     = main_q.data1;
    assign bus.out_data2     = main_q.data2;
    assign bus.out_select    = main_q.sel;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_illegal   = main_q.ill;
endmodule
